// File: rtl/program_loader.sv
// Streams words over valid/ready into the computer's RAM through its manual-programming
// port, then hands the RAM back and releases the CPU reset. Optional readback check: LOADER_VERIFY_EN.
module program_loader #(
   parameter int N          = 8,
   parameter int A          = 4,
   parameter int WE_CYCLES  = 2,
   parameter int RST_CYCLES = 4
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         start,
   input  logic [N-1:0] in_data,
   input  logic         in_valid,
   input  logic         in_last,
   output logic         in_ready,
   input  logic [N-1:0] memval,
   output logic [A-1:0] prog_mar,
   output logic [N-1:0] prog_dat,
   output logic         prog,
   output logic         prog_we_,
   output logic         cpu_rst,
   output logic         busy,
   output logic         done,
   output logic [A:0]   count,
   output logic         err
);

   localparam int TMAX = (WE_CYCLES > RST_CYCLES) ? WE_CYCLES : RST_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] WE_LAST  = TW'(WE_CYCLES - 1);
   localparam logic [TW-1:0] RST_LAST = TW'(RST_CYCLES - 1);
   localparam logic [A-1:0]  MAR_MAX  = {A{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_SETUP, S_STROBE, S_HOLD, S_RELEASE
   } state_t;

   state_t         state_reg, state_next;
   logic [TW-1:0]  timer_reg, timer_next;
   logic [A-1:0]   mar_reg, mar_next;
   logic [N-1:0]   dat_reg, dat_next;
   logic [A:0]     count_reg, count_next;
   logic           last_reg, last_next;
   logic           prog_reg, prog_next;
   logic           we_n_reg, we_n_next;
   logic           cpu_rst_reg, cpu_rst_next;
   logic           in_ready_reg, in_ready_next;
   logic           busy_reg, busy_next;
   logic           done_reg, done_next;

`ifdef LOADER_VERIFY_EN
   logic           err_reg, err_next;
`else
   logic           unused_memval;
   assign unused_memval = ^memval;
`endif

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_reg    <= S_IDLE;
         timer_reg    <= '0;
         mar_reg      <= '0;
         dat_reg      <= '0;
         count_reg    <= '0;
         last_reg     <= 1'b0;
         prog_reg     <= 1'b1;
         we_n_reg     <= 1'b1;
         cpu_rst_reg  <= 1'b0;
         in_ready_reg <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
`ifdef LOADER_VERIFY_EN
         err_reg      <= 1'b0;
`endif
      end else begin
         state_reg    <= state_next;
         timer_reg    <= timer_next;
         mar_reg      <= mar_next;
         dat_reg      <= dat_next;
         count_reg    <= count_next;
         last_reg     <= last_next;
         prog_reg     <= prog_next;
         we_n_reg     <= we_n_next;
         cpu_rst_reg  <= cpu_rst_next;
         in_ready_reg <= in_ready_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
`ifdef LOADER_VERIFY_EN
         err_reg      <= err_next;
`endif
      end
   end

   always_comb begin
      state_next   = state_reg;
      timer_next   = timer_reg;
      mar_next     = mar_reg;
      dat_next     = dat_reg;
      count_next   = count_reg;
      last_next    = last_reg;
      prog_next    = prog_reg;
      cpu_rst_next = cpu_rst_reg;
      done_next    = 1'b0;
`ifdef LOADER_VERIFY_EN
      err_next     = err_reg;
`endif

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               mar_next     = '0;
               count_next   = '0;
               prog_next    = 1'b0;
               cpu_rst_next = 1'b1;
`ifdef LOADER_VERIFY_EN
               err_next     = 1'b0;
`endif
               state_next   = S_WAIT;
            end
         end
         S_WAIT: begin
            // in_ready_reg is high exactly while in WAIT, so this is the handshake
            if (in_valid && in_ready_reg) begin
               dat_next   = in_data;
               last_next  = in_last;
               state_next = S_SETUP;
            end
         end
         S_SETUP: begin
            timer_next = '0;
            state_next = S_STROBE;
         end
         S_STROBE: begin
            if (timer_reg == WE_LAST) begin
               state_next = S_HOLD;
            end else begin
               timer_next = timer_reg + TW'(1);
            end
         end
         S_HOLD: begin
            count_next = count_reg + (A+1)'(1);
`ifdef LOADER_VERIFY_EN
            if (memval != dat_reg) begin
               err_next = 1'b1;
            end
`endif
            // the last RAM location ends the load rather than wrapping to 0
            if (last_reg || (mar_reg == MAR_MAX)) begin
               prog_next  = 1'b1;
               timer_next = '0;
               state_next = S_RELEASE;
            end else begin
               mar_next   = mar_reg + A'(1);
               state_next = S_WAIT;
            end
         end
         S_RELEASE: begin
            if (timer_reg == RST_LAST) begin
               cpu_rst_next = 1'b0;
               done_next    = 1'b1;
               state_next   = S_IDLE;
            end else begin
               timer_next = timer_reg + TW'(1);
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      // these outputs follow the state being entered so they are aligned with it
      in_ready_next = (state_next == S_WAIT);
      we_n_next     = (state_next != S_STROBE);
      busy_next     = (state_next != S_IDLE);
   end

   assign in_ready = in_ready_reg;
   assign prog_mar = mar_reg;
   assign prog_dat = dat_reg;
   assign prog     = prog_reg;
   assign prog_we_ = we_n_reg;
   assign cpu_rst  = cpu_rst_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;
   assign count    = count_reg;
`ifdef LOADER_VERIFY_EN
   assign err      = err_reg;
`else
   assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: RAM model on the programming port, write
// scoreboard, strobe/release length monitors.
module tb_program_loader;

   localparam int N = 8;
   localparam int A = 4;

   logic         clk = 1'b0;
   logic         clr = 1'b1;
   logic         start = 1'b0;
   logic [N-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_last = 1'b0;
   logic         in_ready;
   logic [N-1:0] memval;
   logic [A-1:0] prog_mar;
   logic [N-1:0] prog_dat;
   logic         prog, prog_we_, cpu_rst, busy, done, err;
   logic [A:0]   count;

   program_loader #(.N(N), .A(A), .WE_CYCLES(2), .RST_CYCLES(4)) dut (
      .clk(clk), .clr(clr), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready), .memval(memval), .prog_mar(prog_mar),
      .prog_dat(prog_dat), .prog(prog), .prog_we_(prog_we_), .cpu_rst(cpu_rst),
      .busy(busy), .done(done), .count(count), .err(err)
   );

   always #5 clk = ~clk;

`ifdef LOADER_VERIFY_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   // RAM model of the computer, written while prog=0 and the strobe is low
   logic [N-1:0] ram [16];
   logic         force_en = 1'b0;
   assign memval = (force_en && prog_mar == 4'd1) ? 8'h00 : ram[prog_mar];
   always @(posedge clk) if (!prog && !prog_we_) ram[prog_mar] <= prog_dat;

   int tests = 0, fails = 0;
   int done_cnt = 0, low_run = 0, rel_len = 0, mar_bad = 0;
   logic         prev_we = 1'b1;
   logic [A-1:0] prev_mar = '0;
   logic [11:0]  wr_q[$], exp_q[$];
   int           runs[$], rels[$];
   logic [A-1:0] exp_addr = '0;

   always @(negedge clk) begin
      if (!prog_we_) begin
         low_run++;
         if (prev_we) wr_q.push_back({prog_mar, prog_dat});
         else if (prog_mar != prev_mar) mar_bad++;
      end else if (low_run != 0) begin
         runs.push_back(low_run);
         low_run = 0;
      end
      if (prog_mar != prev_mar && prog_mar != prev_mar + 4'd1 && prog_mar != 4'd0) mar_bad++;
      if (cpu_rst && prog) rel_len++;
      else if (rel_len != 0) begin
         rels.push_back(rel_len);
         rel_len = 0;
      end
      if (done) done_cnt++;
      prev_we  = prog_we_;
      prev_mar = prog_mar;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic reset_sb();
      wr_q.delete(); exp_q.delete(); runs.delete(); rels.delete();
      done_cnt = 0; mar_bad = 0;
   endtask

   task automatic do_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      exp_addr = '0;
   endtask

   task automatic send(input logic [N-1:0] d, input logic last, input bit bp,
                       input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (bp && $urandom_range(0, 1) == 0) begin
            in_valid = 1'b0;
            continue;
         end
         in_valid = 1'b1; in_data = d; in_last = last;
         if (in_ready) begin
            @(posedge clk);
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         exp_q.push_back({exp_addr, d});
         exp_addr = exp_addr + 4'd1;
      end
   endtask

   task automatic wait_done(input string tag);
      bit got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) begin got = 1'b1; break; end
      end
      #1;
      chk(tag, 32'(got), 1);
   endtask

   task automatic check_sb(input string tag);
      logic [11:0] e, w;
      chk({tag, " writes"}, wr_q.size(), exp_q.size());
      while (exp_q.size() > 0 && wr_q.size() > 0) begin
         e = exp_q.pop_front();
         w = wr_q.pop_front();
         $display("[TB] %s write addr=%0d data=%02h (expected addr=%0d data=%02h)",
                  tag, w[11:8], w[7:0], e[11:8], e[7:0]);
         chk({tag, " write"}, w, e);
         chk({tag, " ram"}, ram[e[11:8]], e[7:0]);
      end
      while (runs.size() > 0) chk({tag, " we_len"}, runs.pop_front(), 2);
      chk({tag, " mar_steps"}, mar_bad, 0);
   endtask

   initial begin
      bit ok;
      logic [N-1:0] d;

      repeat (3) @(negedge clk);
      #1;
      chk("rst prog", prog, 1);         chk("rst prog_we_", prog_we_, 1);
      chk("rst cpu_rst", cpu_rst, 0);   chk("rst in_ready", in_ready, 0);
      chk("rst busy", busy, 0);         chk("rst done", done, 0);
      chk("rst count", count, 0);       chk("rst err", err, 0);
      chk("rst prog_mar", prog_mar, 0); chk("rst prog_dat", prog_dat, 0);
      @(negedge clk) clr = 1'b0;

      // clr while the write strobe is low
      do_start();
      #1;
      chk("start busy", busy, 1);       chk("start prog", prog, 0);
      chk("start cpu_rst", cpu_rst, 1); chk("start in_ready", in_ready, 1);
      send(8'h11, 1'b0, 1'b0, 20, ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!prog_we_) begin ok = 1'b1; break; end
      end
      chk("strobe reached", 32'(ok), 1);
      #2 clr = 1'b1;
      #1;
      chk("clr prog", prog, 1);         chk("clr prog_we_", prog_we_, 1);
      chk("clr cpu_rst", cpu_rst, 0);   chk("clr busy", busy, 0);
      chk("clr in_ready", in_ready, 0);
      in_valid = 1'b0;
      @(negedge clk) clr = 1'b0;
      #1 reset_sb();

      // three words with in_valid held, plus a start pulse while busy
      do_start();
      send(8'h1E, 1'b0, 1'b0, 20, ok);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      send(8'h2F, 1'b0, 1'b0, 20, ok);
      send(8'hE0, 1'b1, 1'b0, 20, ok);
      @(negedge clk) in_valid = 1'b0;
      wait_done("t2 done");
      check_sb("t2");
      chk("t2 count", count, 3);
      chk("t2 rel_runs", rels.size(), 1);
      if (rels.size() > 0) chk("t2 rel_len", rels.pop_front(), 4);
      chk("t2 prog", prog, 1);          chk("t2 cpu_rst", cpu_rst, 0);
      chk("t2 err", err, 0);
      repeat (3) @(negedge clk);
      #1;
      chk("t2 done pulses", done_cnt, 1);
      chk("t2 busy", busy, 0);

      // random back-pressure
      reset_sb();
      do_start();
      for (int i = 0; i < 6; i++) begin
         d = 8'($urandom_range(0, 255));
         send(d, (i == 5), 1'b1, 100, ok);
         chk("t3 accepted", 32'(ok), 1);
      end
      @(negedge clk) in_valid = 1'b0;
      wait_done("t3 done");
      check_sb("t3");
      chk("t3 count", count, 6);

      // 17 words without in_last: the 17th is never accepted
      reset_sb();
      do_start();
      for (int i = 0; i < 16; i++) begin
         send(8'(i * 17 + 3), 1'b0, 1'b0, 20, ok);
      end
      send(8'hAA, 1'b0, 1'b0, 20, ok);
      chk("t4 17th refused", 32'(ok), 0);
      @(negedge clk) in_valid = 1'b0;
      #1;
      check_sb("t4");
      chk("t4 count", count, 16);
      chk("t4 done pulses", done_cnt, 1);
      chk("t4 busy", busy, 0);
      chk("t4 prog", prog, 1);

      // readback mismatch on word 2
      reset_sb();
      do_start();
      send(8'h33, 1'b0, 1'b0, 20, ok);
      force_en = 1'b1;
      send(8'h5A, 1'b0, 1'b0, 20, ok);
      send(8'h77, 1'b1, 1'b0, 20, ok);
      force_en = 1'b0;
      @(negedge clk) in_valid = 1'b0;
      wait_done("t6 done");
      chk("t6 err", err, EXP_ERR);
      repeat (5) @(negedge clk);
      #1;
      chk("t6 err sticky", err, EXP_ERR);
      do_start();
      #1;
      chk("t6 err cleared", err, 0);
      send(8'h01, 1'b1, 1'b0, 20, ok);
      @(negedge clk) in_valid = 1'b0;
      wait_done("t6b done");
      chk("t6b err", err, 0);
      chk("t6b count", count, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
